pic_host_sequencer: RTL and testbench

//  CPU-side initiator for the 8259A-style interrupt controller. After init_start, writes ICW1..ICW4 and OCW1

---
 rtl/pic_host_pkg.sv | 54 +++++
 rtl/pic_strobe_timer.sv | 27 ++
 rtl/pic_host_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_pic_host_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_host_pkg.sv
// Shared types and 8259A command-word encodings for the PIC host sequencer.
package pic_host_pkg;

    typedef enum logic [3:0] {
        ST_UNINIT,
        ST_W_SETUP,
        ST_W_STROBE,
        ST_W_HOLD,
        ST_READY,
        ST_ACK1,
        ST_ACK_GAP,
        ST_ACK2,
        ST_VEC_OUT
    } pic_state_e;

    localparam int ICW1_IC4_BIT  = 0;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_ADI_BIT  = 2;
    localparam int ICW1_LTIM_BIT = 3;
    localparam int ICW1_D4_BIT   = 4;

    localparam int ICW4_UPM_BIT  = 0;
    localparam int ICW4_AEOI_BIT = 1;

    localparam int OCW2_EOI_BIT  = 5;
    localparam logic [7:0] OCW2_NS_EOI = 8'h20;

    // Index of the byte being written during the init walk.
    localparam logic [2:0] IDX_ICW1 = 3'd0;
    localparam logic [2:0] IDX_ICW2 = 3'd1;
    localparam logic [2:0] IDX_ICW3 = 3'd2;
    localparam logic [2:0] IDX_ICW4 = 3'd3;
    localparam logic [2:0] IDX_OCW1 = 3'd4;

    function automatic logic [7:0] icw1_byte(input logic ltim, input logic sngl);
        logic [7:0] b;
        b                = '0;
        b[ICW1_IC4_BIT]  = 1'b1;
        b[ICW1_SNGL_BIT] = sngl;
        b[ICW1_ADI_BIT]  = 1'b0;
        b[ICW1_LTIM_BIT] = ltim;
        b[ICW1_D4_BIT]   = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] icw4_byte(input logic aeoi);
        logic [7:0] b;
        b                = '0;
        b[ICW4_UPM_BIT]  = 1'b1;
        b[ICW4_AEOI_BIT] = aeoi;
        return b;
    endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Shared down-counter for write-strobe, INTA pulse and INTA gap timing; done marks the last cycle.
module pic_strobe_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          count_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign done_o = (cnt_q == TW'(1));

endmodule

// File: rtl/pic_host_sequencer.sv
// CPU-side 8259A initiator: init writes, two-pulse INTA with vector capture, valid/ready hand-off.
// Optional non-specific EOI command path is built when PIC_EOI_CMD_EN is defined.
module pic_host_sequencer
    import pic_host_pkg::*;
#(
    parameter int          WR_PULSE   = 2,
    parameter int          INTA_PULSE = 2,
    parameter int          INTA_GAP   = 2,
    parameter logic [4:0]  VEC_BASE   = 5'b10010,
    parameter bit          SNGL       = 1'b1,
    parameter logic [7:0]  ICW3_VAL   = 8'h00,
    parameter bit          LTIM       = 1'b0,
    parameter logic [7:0]  IMR_INIT   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_start,
    output logic       init_done,
    input  logic       pic_int,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] dbus_out,
    output logic       dbus_oe,
    input  logic [7:0] dbus_in,
    output logic       inta_n,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       busy
);

    localparam int TMAX = (WR_PULSE > INTA_PULSE) ?
                          ((WR_PULSE > INTA_GAP) ? WR_PULSE : INTA_GAP) :
                          ((INTA_PULSE > INTA_GAP) ? INTA_PULSE : INTA_GAP);
    localparam int TW = $clog2(TMAX) + 1;

`ifdef PIC_EOI_CMD_EN
    localparam logic AEOI = 1'b0;
`else
    localparam logic AEOI = 1'b1;
`endif

    pic_state_e  state_q;
    logic [2:0]  idx_q;
    logic        eoi_wr_q;
    logic        cs_n_q, wr_n_q, a0_q, oe_q, inta_n_q, vec_valid_q, init_done_q;
    logic [7:0]  dbus_q, vec_q;
    logic [1:0]  int_sync_q;
    logic        int_sync;
    logic        eoi_pend;
    logic        go_init, go_eoi, go_ack;
    logic        tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;
    logic [2:0]  idx_d;

    function automatic logic [8:0] init_byte(input logic [2:0] idx);
        logic [8:0] b;
        case (idx)
            IDX_ICW1: b = {1'b0, icw1_byte(LTIM, SNGL)};
            IDX_ICW2: b = {1'b1, VEC_BASE, 3'b000};
            IDX_ICW3: b = {1'b1, ICW3_VAL};
            IDX_ICW4: b = {1'b1, icw4_byte(AEOI)};
            default:  b = {1'b1, IMR_INIT};
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_sync_q <= '0;
        end else begin
            int_sync_q <= {int_sync_q[0], pic_int};
        end
    end
    assign int_sync = int_sync_q[1];

`ifdef PIC_EOI_CMD_EN
    logic eoi_pend_q;
    // A request arriving in the same cycle the pending one is consumed stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eoi_pend_q <= 1'b0;
        end else if (go_init || go_eoi) begin
            eoi_pend_q <= eoi_req;
        end else if (eoi_req) begin
            eoi_pend_q <= 1'b1;
        end
    end
    assign eoi_pend = eoi_pend_q;
`else
    logic unused_eoi_req;
    assign unused_eoi_req = eoi_req;
    assign eoi_pend       = 1'b0;
`endif

    assign go_init = init_start && ((state_q == ST_UNINIT) || (state_q == ST_READY));
    assign go_eoi  = (state_q == ST_READY) && !init_start && eoi_pend;
    assign go_ack  = (state_q == ST_READY) && !init_start && !eoi_pend && int_sync;
    assign idx_d   = ((idx_q == IDX_ICW2) && SNGL) ? IDX_ICW4 : idx_q + 3'd1;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TW'(WR_PULSE);
        case (state_q)
            ST_W_SETUP: tmr_load = 1'b1;
            ST_READY: begin
                tmr_load = go_ack;
                tmr_val  = TW'(INTA_PULSE);
            end
            ST_ACK1: begin
                tmr_load = tmr_done;
                tmr_val  = TW'(INTA_GAP);
            end
            ST_ACK_GAP: begin
                tmr_load = tmr_done;
                tmr_val  = TW'(INTA_PULSE);
            end
            default: ;
        endcase
    end

    pic_strobe_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_i    (busy),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNINIT;
            idx_q       <= IDX_ICW1;
            eoi_wr_q    <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            dbus_q      <= '0;
            oe_q        <= 1'b0;
            inta_n_q    <= 1'b1;
            vec_valid_q <= 1'b0;
            vec_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_UNINIT, ST_READY: begin
                    if (go_init) begin
                        idx_q          <= IDX_ICW1;
                        eoi_wr_q       <= 1'b0;
                        {a0_q, dbus_q} <= init_byte(IDX_ICW1);
                        cs_n_q         <= 1'b0;
                        oe_q           <= 1'b1;
                        state_q        <= ST_W_SETUP;
                    end else if (go_eoi) begin
                        eoi_wr_q <= 1'b1;
                        a0_q     <= 1'b0;
                        dbus_q   <= OCW2_NS_EOI;
                        cs_n_q   <= 1'b0;
                        oe_q     <= 1'b1;
                        state_q  <= ST_W_SETUP;
                    end else if (go_ack) begin
                        inta_n_q <= 1'b0;
                        state_q  <= ST_ACK1;
                    end
                end
                ST_W_SETUP: begin
                    wr_n_q  <= 1'b0;
                    state_q <= ST_W_STROBE;
                end
                ST_W_STROBE: begin
                    if (tmr_done) begin
                        wr_n_q  <= 1'b1;
                        state_q <= ST_W_HOLD;
                    end
                end
                ST_W_HOLD: begin
                    if (!eoi_wr_q && (idx_q != IDX_OCW1)) begin
                        idx_q          <= idx_d;
                        {a0_q, dbus_q} <= init_byte(idx_d);
                        state_q        <= ST_W_SETUP;
                    end else begin
                        cs_n_q  <= 1'b1;
                        oe_q    <= 1'b0;
                        a0_q    <= 1'b0;
                        dbus_q  <= '0;
                        if (!eoi_wr_q) init_done_q <= 1'b1;
                        eoi_wr_q <= 1'b0;
                        state_q  <= ST_READY;
                    end
                end
                ST_ACK1: begin
                    if (tmr_done) begin
                        inta_n_q <= 1'b1;
                        state_q  <= ST_ACK_GAP;
                    end
                end
                ST_ACK_GAP: begin
                    if (tmr_done) begin
                        inta_n_q <= 1'b0;
                        state_q  <= ST_ACK2;
                    end
                end
                ST_ACK2: begin
                    // Vector is taken on the last low cycle; a spurious IR7 is passed through as-is.
                    if (tmr_done) begin
                        inta_n_q    <= 1'b1;
                        vec_q       <= dbus_in;
                        vec_valid_q <= 1'b1;
                        state_q     <= ST_VEC_OUT;
                    end
                end
                ST_VEC_OUT: begin
                    if (vec_ready) begin
                        vec_valid_q <= 1'b0;
                        state_q     <= ST_READY;
                    end
                end
                default: state_q <= ST_UNINIT;
            endcase
        end
    end

    assign busy      = (state_q != ST_UNINIT) && (state_q != ST_READY);
    assign cs_n      = cs_n_q;
    assign wr_n      = wr_n_q;
    assign a0        = a0_q;
    assign dbus_out  = dbus_q;
    assign dbus_oe   = oe_q;
    assign inta_n    = inta_n_q;
    assign vec_valid = vec_valid_q;
    assign vec_data  = vec_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed self-checking bench for pic_host_sequencer (single and cascade configurations).
module tb_pic_host_sequencer;

    logic       clk = 1'b0;
    logic       rst, init_start, pic_int, vec_ready, eoi_req;
    logic [7:0] dbus_in, pic_vec;
    logic       cs_n, wr_n, a0, dbus_oe, inta_n, vec_valid, init_done, busy;
    logic [7:0] dbus_out, vec_data;
    logic       d2_cs_n, d2_wr_n, d2_a0, d2_oe, d2_inta_n, d2_vv, d2_init_done, d2_busy;
    logic [7:0] d2_dbus, d2_vec;

    int checks = 0;
    int failures = 0;

`ifdef PIC_EOI_CMD_EN
    localparam logic [7:0] ICW4_EXP = 8'h01;
`else
    localparam logic [7:0] ICW4_EXP = 8'h03;
`endif

    always #5 clk = ~clk;

    pic_host_sequencer #(.SNGL(1'b1), .IMR_INIT(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .init_start(init_start), .init_done(init_done),
        .pic_int(pic_int), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .dbus_out(dbus_out),
        .dbus_oe(dbus_oe), .dbus_in(dbus_in), .inta_n(inta_n), .vec_valid(vec_valid),
        .vec_data(vec_data), .vec_ready(vec_ready), .eoi_req(eoi_req), .busy(busy)
    );

    pic_host_sequencer #(.SNGL(1'b0), .ICW3_VAL(8'h04), .IMR_INIT(8'h3C)) u_dut2 (
        .clk(clk), .rst(rst), .init_start(init_start), .init_done(d2_init_done),
        .pic_int(1'b0), .cs_n(d2_cs_n), .wr_n(d2_wr_n), .a0(d2_a0), .dbus_out(d2_dbus),
        .dbus_oe(d2_oe), .dbus_in(8'h00), .inta_n(d2_inta_n), .vec_valid(d2_vv),
        .vec_data(d2_vec), .vec_ready(1'b0), .eoi_req(1'b0), .busy(d2_busy)
    );

    // PIC model: drives the vector only during the second INTA pulse of a pair.
    int ia_cnt;
    always @(negedge inta_n or posedge rst) begin
        if (rst) ia_cnt <= 0;
        else     ia_cnt <= ia_cnt + 1;
    end
    assign dbus_in = (!inta_n && (ia_cnt % 2 == 0)) ? pic_vec : 8'hEE;

    // Write-cycle recorders: {cs_n, oe, a0, data} sampled on the first low cycle, plus low length.
    logic [10:0] wr_log[$], wr2_log[$];
    int wr_len[$];
    int lo1 = 0, lo2 = 0;
    logic [10:0] cap1, cap2;
    always @(negedge clk) begin
        if (rst) begin
            lo1 = 0;
            lo2 = 0;
        end else begin
            if (!wr_n) begin
                if (lo1 == 0) cap1 = {cs_n, dbus_oe, a0, dbus_out};
                lo1++;
            end else if (lo1 != 0) begin
                wr_log.push_back(cap1);
                wr_len.push_back(lo1);
                lo1 = 0;
            end
            if (!d2_wr_n) begin
                if (lo2 == 0) cap2 = {d2_cs_n, d2_oe, d2_a0, d2_dbus};
                lo2++;
            end else if (lo2 != 0) begin
                wr2_log.push_back(cap2);
                lo2 = 0;
            end
        end
    end

    // INTA recorder: low pulse lengths and the high run preceding each pulse.
    int ia_len[$], ia_gap[$];
    int ia_lo = 0, ia_hi = 0;
    always @(negedge clk) begin
        if (rst) begin
            ia_lo = 0;
            ia_hi = 0;
        end else if (!inta_n) begin
            if (ia_lo == 0) ia_gap.push_back(ia_hi);
            ia_lo++;
            ia_hi = 0;
        end else begin
            if (ia_lo != 0) begin
                ia_len.push_back(ia_lo);
                ia_lo = 0;
            end
            ia_hi++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        tick(1);
        init_start = 1'b0;
    endtask

    task automatic accept();
        vec_ready = 1'b1;
        tick(1);
        vec_ready = 1'b0;
    endtask

    logic [10:0] exp1[4];
    logic [10:0] exp2[5];
    logic        stable;
    int          n0;

    initial begin
        exp1[0] = {2'b01, 1'b0, 8'h13};
        exp1[1] = {2'b01, 1'b1, 8'h90};
        exp1[2] = {2'b01, 1'b1, ICW4_EXP};
        exp1[3] = {2'b01, 1'b1, 8'hA5};
        exp2[0] = {2'b01, 1'b0, 8'h11};
        exp2[1] = {2'b01, 1'b1, 8'h90};
        exp2[2] = {2'b01, 1'b1, 8'h04};
        exp2[3] = {2'b01, 1'b1, ICW4_EXP};
        exp2[4] = {2'b01, 1'b1, 8'h3C};

        rst = 1'b1; init_start = 1'b0; pic_int = 1'b0; vec_ready = 1'b0;
        eoi_req = 1'b0; pic_vec = 8'h92;
        tick(3);
        chk("reset_ctl", {cs_n, wr_n, inta_n, a0, dbus_oe, vec_valid, init_done, busy}, 8'b1110_0000);
        chk("reset_data", {dbus_out, vec_data}, 16'h0000);
        rst = 1'b0;
        tick(2);

        // Init, single PIC; a second init_start while busy must be ignored.
        pulse_init();
        chk("busy_init", busy, 1'b1);
        tick(5);
        pulse_init();
        for (int i = 0; i < 100 && !init_done; i++) tick(1);
        chk("init_done", init_done, 1'b1);
        chk("init_busy_low", busy, 1'b0);
        chk("wr_count", wr_log.size(), 4);
        for (int i = 0; i < wr_log.size() && i < 4; i++) begin
            chk($sformatf("wr_byte%0d", i), wr_log[i], exp1[i]);
            chk($sformatf("wr_len%0d", i), wr_len[i], 2);
        end
        chk("bus_idle", {cs_n, dbus_oe}, 2'b10);

        // Cascade configuration includes ICW3.
        for (int i = 0; i < 100 && !d2_init_done; i++) tick(1);
        chk("d2_init_done", d2_init_done, 1'b1);
        chk("d2_wr_count", wr2_log.size(), 5);
        for (int i = 0; i < wr2_log.size() && i < 5; i++)
            chk($sformatf("d2_byte%0d", i), wr2_log[i], exp2[i]);

        // Interrupt acknowledge.
        ia_len.delete(); ia_gap.delete();
        pic_int = 1'b1;
        for (int i = 0; i < 60 && !vec_valid; i++) tick(1);
        chk("vec_valid", vec_valid, 1'b1);
        chk("vec_data", vec_data, 8'h92);
        tick(1);
        chk("inta_pulses", ia_len.size(), 2);
        if (ia_len.size() == 2) begin
            chk("inta_len1", ia_len[0], 2);
            chk("inta_len2", ia_len[1], 2);
            chk("inta_gap", ia_gap[1], 2);
        end

        // Back-pressure: vector held, no further INTA while pic_int stays high.
        stable = 1'b1;
        n0 = ia_gap.size();
        for (int i = 0; i < 10; i++) begin
            if (vec_valid !== 1'b1 || vec_data !== 8'h92 || inta_n !== 1'b1) stable = 1'b0;
            tick(1);
        end
        chk("hold_stable", stable, 1'b1);
        chk("hold_no_inta", ia_gap.size(), n0);
        pic_vec = 8'h93;
        accept();
        chk("accept_drop", {vec_valid, inta_n}, 2'b01);
        tick(1);
        chk("reack_from_ready", inta_n, 1'b0);
        for (int i = 0; i < 60 && !vec_valid; i++) tick(1);
        chk("vec2_data", vec_data, 8'h93);
        pic_int = 1'b0;
        tick(3);
        accept();
        tick(4);
        chk("idle_after", {inta_n, busy}, 2'b10);

        // pic_int withdrawn mid-sequence: PIC returns IR7, forwarded unchanged.
        pic_vec = 8'h97;
        pic_int = 1'b1;
        for (int i = 0; i < 20 && inta_n; i++) tick(1);
        pic_int = 1'b0;
        for (int i = 0; i < 60 && !vec_valid; i++) tick(1);
        chk("spurious_vec", vec_data, 8'h97);
        accept();
        tick(4);
        chk("spurious_idle", busy, 1'b0);

`ifdef PIC_EOI_CMD_EN
        pic_vec = 8'h92;
        pic_int = 1'b1;
        for (int i = 0; i < 60 && !(inta_n == 1'b0 && ia_cnt % 2 == 0); i++) tick(1);
        eoi_req = 1'b1;
        tick(1);
        eoi_req = 1'b0;
        for (int i = 0; i < 60 && !vec_valid; i++) tick(1);
        wr_log.delete();
        accept();
        for (int i = 0; i < 60 && inta_n; i++) tick(1);
        chk("eoi_before_inta", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("eoi_byte", wr_log[0], {2'b01, 1'b0, 8'h20});
        pic_int = 1'b0;
        for (int i = 0; i < 60 && !vec_valid; i++) tick(1);
        accept();
        tick(4);
        chk("eoi_init_kept", {init_done, busy}, 2'b10);
`else
        wr_log.delete();
        eoi_req = 1'b1;
        tick(1);
        eoi_req = 1'b0;
        tick(12);
        chk("eoi_ignored", wr_log.size(), 0);
`endif

        // Reset during W_STROBE.
        pulse_init();
        for (int i = 0; i < 20 && wr_n; i++) tick(1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wr", {wr_n, cs_n, inta_n, dbus_oe, init_done, busy}, 6'b111000);
        tick(1);
        rst = 1'b0;
        tick(1);
        pulse_init();
        for (int i = 0; i < 100 && !init_done; i++) tick(1);
        chk("reinit_done", init_done, 1'b1);

        // Reset during ACK2.
        pic_int = 1'b1;
        for (int i = 0; i < 60 && !(inta_n == 1'b0 && ia_cnt == 2); i++) tick(1);
        #2 rst = 1'b1;
        #1;
        chk("rst_ack", {inta_n, cs_n, wr_n, vec_valid, init_done, busy}, 6'b111000);
        tick(1);
        rst = 1'b0;
        ia_gap.delete();
        tick(6);
        chk("uninit_no_ack", {ia_gap.size() == 0, inta_n}, 2'b11);
        pic_int = 1'b0;
        wr_log.delete();
        tick(3);
        pulse_init();
        for (int i = 0; i < 100 && !init_done; i++) tick(1);
        chk("final_init", {init_done, 8'(wr_log.size())}, {1'b1, 8'd4});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
